mem_arbiter: RTL and testbench

Shares the single unified `mem_system` instance between the instruction-fetch port and the data-memory port of the pipelined core. It arbitrates one transaction at a time, with data priority and a starvation guard for fetch. It issues the transaction to memory and returns completion and stall handshakes to each requester. It also discards in-flight fetches squashed by a taken branch.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_starve_ctr.sv | 39 +++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and state encoding for the fetch/data memory arbiter.
// The starvation counter is 2 bits wide, so the starvation limit must stay at or below 3.
package mem_arb_pkg;

   localparam int unsigned DATA_W           = 16;
   localparam int unsigned STARVE_W         = 2;
   localparam int unsigned STARVE_LIMIT_DEF = 2;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE_I = 3'd1;
   localparam logic [2:0] ST_ISSUE_D = 3'd2;
   localparam logic [2:0] ST_WAIT_I  = 3'd3;
   localparam logic [2:0] ST_WAIT_D  = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      ISSUE_I = ST_ISSUE_I,
      ISSUE_D = ST_ISSUE_D,
      WAIT_I  = ST_WAIT_I,
      WAIT_D  = ST_WAIT_D
   } arb_state_e;

   function automatic logic is_fetch_state(input arb_state_e s);
      return (s == ISSUE_I) || (s == WAIT_I);
   endfunction

   function automatic logic is_data_state(input arb_state_e s);
      return (s == ISSUE_D) || (s == WAIT_D);
   endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants made while a fetch was waiting.
// A clear request takes priority over an increment request.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = STARVE_LIMIT_DEF
)
(
   input  logic clk,
   input  logic rst,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(LIMIT);

   logic [STARVE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < LIMIT_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q >= LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Data has priority; a bounded starvation counter guarantees fetch progress.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [DATA_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              dm_stall,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   input  logic              mem_err,
   output logic              err
);

   arb_state_e        state_q, state_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
   logic              dir_q, dir_d;
   logic              cancel_q, cancel_d;
   logic              err_q, err_d;

   logic in_idle, in_fetch, in_data;
   logic fetch_ok, at_limit, grant_i, grant_d;
   logic cancel_now, fetch_drop, data_drop;

   assign in_idle    = (state_q == IDLE);
   assign in_fetch   = is_fetch_state(state_q);
   assign in_data    = is_data_state(state_q);
   assign cancel_now = cancel_q | if_flush;

   // A flush in the arbitration cycle only blocks that cycle's fetch grant.
   assign fetch_ok = if_req & ~if_flush;
   assign grant_i  = in_idle & fetch_ok & (~dm_req | at_limit);
   assign grant_d  = in_idle & dm_req & ~(fetch_ok & at_limit);

   mem_arb_starve_ctr #(
      .LIMIT      (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (grant_d & if_req),
      .clr_i      (grant_i | (grant_d & ~if_req)),
      .at_limit_o (at_limit)
   );

   always_comb begin
      state_d = state_q;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      if_done = 1'b0;
      dm_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = ISSUE_D;
            end else if (grant_i) begin
               state_d = ISSUE_I;
            end
         end
         ISSUE_I, WAIT_I: begin
            mem_rd = (state_q == ISSUE_I);
            if (mem_done) begin
               state_d = IDLE;
               if_done = ~cancel_now;
            end else begin
               state_d = WAIT_I;
            end
         end
         ISSUE_D, WAIT_D: begin
            mem_rd = (state_q == ISSUE_D) & ~dir_q;
            mem_wr = (state_q == ISSUE_D) &  dir_q;
            if (mem_done) begin
               state_d = IDLE;
               dm_done = 1'b1;
            end else begin
               state_d = WAIT_D;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A fetch that has been flushed may legally drop its request early.
   assign fetch_drop = in_fetch & ~if_req & ~cancel_now;
   assign data_drop  = in_data & ~dm_req;

   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      dir_d       = dir_q;
      if (grant_d) begin
         mem_addr_d  = dm_addr;
         mem_wdata_d = dm_wdata;
         dir_d       = dm_wr;
      end else if (grant_i) begin
         mem_addr_d  = if_addr;
         mem_wdata_d = '0;
         dir_d       = 1'b0;
      end

      cancel_d = cancel_q;
      if (in_fetch) begin
         if (mem_done) begin
            cancel_d = 1'b0;
         end else if (if_flush) begin
            cancel_d = 1'b1;
         end
      end

      err_d = err_q
            | (mem_done & mem_err)
            | (mem_done & in_idle)
            | fetch_drop
            | data_drop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         dir_q       <= 1'b0;
         cancel_q    <= 1'b0;
         err_q       <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         dir_q       <= dir_d;
         cancel_q    <= cancel_d;
         err_q       <= err_d;
         if (if_done) begin
            if_rdata_q <= mem_rdata;
         end
         if (dm_done) begin
            dm_rdata_q <= mem_rdata;
         end
      end
   end

   // Read data is forwarded in the done cycle and held from the register afterwards.
   assign if_rdata  = if_done ? mem_rdata : if_rdata_q;
   assign dm_rdata  = dm_done ? mem_rdata : dm_rdata_q;
   assign if_stall  = rst & if_req & ~if_done;
   assign dm_stall  = rst & dm_req & ~dm_done;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [15:0] if_addr;
   logic        if_flush;
   logic [15:0] if_rdata;
   logic        if_done;
   logic        if_stall;
   logic        dm_req;
   logic        dm_wr;
   logic [15:0] dm_addr;
   logic [15:0] dm_wdata;
   logic [15:0] dm_rdata;
   logic        dm_done;
   logic        dm_stall;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_rdata;
   logic        mem_done;
   logic        mem_err;
   logic        err;

   int n_vec;
   int n_miss;
   int rd_cnt;

   logic [15:0] exp_grant [6];

   mem_arbiter #(
      .STARVE_LIMIT (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .if_stall  (if_stall),
      .dm_req    (dm_req),
      .dm_wr     (dm_wr),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_done   (dm_done),
      .dm_stall  (dm_stall),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .mem_err   (mem_err),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   initial begin
      n_vec    = 0;
      n_miss   = 0;
      rd_cnt   = 0;
      exp_grant = '{16'h0300, 16'h0300, 16'h0100, 16'h0300, 16'h0300, 16'h0100};
      rst       = 1'b1;
      if_req    = 1'b0;
      if_addr   = 16'h0000;
      if_flush  = 1'b0;
      dm_req    = 1'b0;
      dm_wr     = 1'b0;
      dm_addr   = 16'h0000;
      dm_wdata  = 16'h0000;
      mem_rdata = 16'h0000;
      mem_done  = 1'b0;
      mem_err   = 1'b0;
      #2 rst = 1'b0;

      // reset state
      @(negedge clk); #1;
      check("rst err", 16'(err), 16'd0);
      check("rst mem_rd", 16'(mem_rd), 16'd0);
      check("rst mem_addr", mem_addr, 16'h0000);
      check("rst if_rdata", if_rdata, 16'h0000);
      @(negedge clk); rst = 1'b1;

      // fetch read, done 3 cycles after the strobe
      @(negedge clk); if_req = 1'b1; if_addr = 16'h0010; #1;
      rd_cnt += int'(mem_rd);
      check("fetch idle stall", 16'(if_stall), 16'd1);
      @(negedge clk); #1;
      rd_cnt += int'(mem_rd);
      check("fetch issue rd", 16'(mem_rd), 16'd1);
      check("fetch issue addr", mem_addr, 16'h0010);
      check("fetch issue wr", 16'(mem_wr), 16'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         rd_cnt += int'(mem_rd);
         check($sformatf("fetch wait%0d stall", i), 16'(if_stall), 16'd1);
         check($sformatf("fetch wait%0d done", i), 16'(if_done), 16'd0);
      end
      @(negedge clk); mem_done = 1'b1; mem_rdata = 16'h1234; #1;
      rd_cnt += int'(mem_rd);
      check("fetch done", 16'(if_done), 16'd1);
      check("fetch done rdata", if_rdata, 16'h1234);
      check("fetch done stall", 16'(if_stall), 16'd0);
      @(negedge clk); mem_done = 1'b0; if_req = 1'b0; mem_rdata = 16'hFFFF; #1;
      rd_cnt += int'(mem_rd);
      check("fetch after done", 16'(if_done), 16'd0);
      check("fetch rdata held", if_rdata, 16'h1234);
      check("fetch rd pulses", 16'(rd_cnt), 16'd1);
      check("fetch err", 16'(err), 16'd0);

      // data write with a hit in the issue cycle, then a back-to-back read
      @(negedge clk); dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'hBEEF; #1;
      check("dwr idle stall", 16'(dm_stall), 16'd1);
      @(negedge clk); mem_done = 1'b1; #1;
      check("dwr mem_wr", 16'(mem_wr), 16'd1);
      check("dwr mem_rd", 16'(mem_rd), 16'd0);
      check("dwr wdata", mem_wdata, 16'hBEEF);
      check("dwr addr", mem_addr, 16'h0200);
      check("dwr done", 16'(dm_done), 16'd1);
      check("dwr stall", 16'(dm_stall), 16'd0);
      @(negedge clk); mem_done = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0202; #1;
      check("dwr idle mem_wr", 16'(mem_wr), 16'd0);
      check("dwr idle done", 16'(dm_done), 16'd0);
      @(negedge clk); mem_done = 1'b1; mem_rdata = 16'h5555; #1;
      check("drd mem_rd", 16'(mem_rd), 16'd1);
      check("drd addr", mem_addr, 16'h0202);
      check("drd rdata", dm_rdata, 16'h5555);
      check("drd done", 16'(dm_done), 16'd1);
      @(negedge clk); mem_done = 1'b0; dm_req = 1'b0; #1;
      check("drd rdata held", dm_rdata, 16'h5555);

      // starvation: both held, every transaction hits in its issue cycle
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) begin
            if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0;
            if_addr = 16'h0100; dm_addr = 16'h0300; mem_rdata = 16'h7777;
         end
         mem_done = ((i % 2) == 1);
         #1;
         if ((i % 2) == 1) begin
            check($sformatf("grant %0d addr", i / 2), mem_addr, exp_grant[i / 2]);
            check($sformatf("grant %0d rd", i / 2), 16'(mem_rd), 16'd1);
         end
      end
      @(negedge clk); if_req = 1'b0; dm_req = 1'b0; mem_done = 1'b0; #1;
      check("starve err", 16'(err), 16'd0);
      check("starve if_rdata", if_rdata, 16'h7777);

      // flush during WAIT_I
      @(negedge clk); if_req = 1'b1; if_addr = 16'h0080; #1;
      @(negedge clk); #1;
      check("flush issue rd", 16'(mem_rd), 16'd1);
      @(negedge clk); if_flush = 1'b1; #1;
      check("flush wait done", 16'(if_done), 16'd0);
      @(negedge clk); if_flush = 1'b0; if_req = 1'b0; mem_done = 1'b1; mem_rdata = 16'hDEAD; #1;
      check("flush no done", 16'(if_done), 16'd0);
      check("flush rdata kept", if_rdata, 16'h7777);
      @(negedge clk); mem_done = 1'b0; if_req = 1'b1; if_addr = 16'h0040; #1;
      check("flush err", 16'(err), 16'd0);
      check("flush rdata held", if_rdata, 16'h7777);
      @(negedge clk); mem_done = 1'b1; mem_rdata = 16'hCAFE; #1;
      check("refetch addr", mem_addr, 16'h0040);
      check("refetch rd", 16'(mem_rd), 16'd1);
      check("refetch done", 16'(if_done), 16'd1);
      check("refetch rdata", if_rdata, 16'hCAFE);
      @(negedge clk); mem_done = 1'b0; if_req = 1'b0; #1;
      check("refetch held", if_rdata, 16'hCAFE);
      check("refetch err", 16'(err), 16'd0);

      // errors: spurious done while IDLE
      @(negedge clk); mem_done = 1'b1; #1;
      @(negedge clk); mem_done = 1'b0; #1;
      check("idle done err", 16'(err), 16'd1);
      @(negedge clk); #1;
      check("idle done err sticky", 16'(err), 16'd1);
      @(negedge clk); rst = 1'b0; #1;
      check("err reset", 16'(err), 16'd0);
      check("rdata reset", if_rdata, 16'h0000);
      @(negedge clk); rst = 1'b1;

      // errors: data request dropped in WAIT_D
      @(negedge clk); dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0400; #1;
      @(negedge clk); #1;
      check("drop issue rd", 16'(mem_rd), 16'd1);
      @(negedge clk); dm_req = 1'b0; #1;
      check("drop err pre", 16'(err), 16'd0);
      @(negedge clk); mem_done = 1'b1; #1;
      check("drop err", 16'(err), 16'd1);
      @(negedge clk); mem_done = 1'b0; #1;
      @(negedge clk); rst = 1'b0; #1;
      check("drop err reset", 16'(err), 16'd0);
      @(negedge clk); rst = 1'b1;

      // reset in WAIT_D, then a fresh read
      @(negedge clk); dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0500; dm_wdata = 16'h1111; #1;
      @(negedge clk); #1;
      check("rmid issue wr", 16'(mem_wr), 16'd1);
      check("rmid issue addr", mem_addr, 16'h0500);
      @(negedge clk); #1;
      check("rmid wait wr", 16'(mem_wr), 16'd0);
      check("rmid wait done", 16'(dm_done), 16'd0);
      #2 rst = 1'b0; #1;
      check("rmid addr", mem_addr, 16'h0000);
      check("rmid wdata", mem_wdata, 16'h0000);
      check("rmid done", 16'(dm_done), 16'd0);
      check("rmid stall", 16'(dm_stall), 16'd0);
      check("rmid mem_wr", 16'(mem_wr), 16'd0);
      @(negedge clk); dm_req = 1'b0; #1;
      check("rmid held done", 16'(dm_done), 16'd0);
      @(negedge clk); rst = 1'b1; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0600; #1;
      check("post rst stall", 16'(dm_stall), 16'd1);
      check("post rst idle rd", 16'(mem_rd), 16'd0);
      @(negedge clk); mem_done = 1'b1; mem_rdata = 16'h4242; #1;
      check("post rst rd", 16'(mem_rd), 16'd1);
      check("post rst addr", mem_addr, 16'h0600);
      check("post rst done", 16'(dm_done), 16'd1);
      check("post rst rdata", dm_rdata, 16'h4242);
      @(negedge clk); mem_done = 1'b0; dm_req = 1'b0; #1;
      check("post rst held", dm_rdata, 16'h4242);
      check("post rst err", 16'(err), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
